alu_exec_unit: RTL

//  Execute-stage ALU that consumes the 3-bit ALUOperation code emitted by alu_control plus two

---
 rtl/alu_exec_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU (add/sub/and/or/slt) with a two-entry
//               registered valid/ready output buffer and a drain counter.
//               Optional macro ALU_OVF_FLAG_EN adds a signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           ALUOperation,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 illegal_op,
`ifdef ALU_OVF_FLAG_EN
  output logic                 overflow,
`endif
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_SLT = 3'b111;

  // Buffer entry layout: {[overflow,] illegal_op, zero, result}
`ifdef ALU_OVF_FLAG_EN
  localparam int c_PW = WIDTH + 3;
`else
  localparam int c_PW = WIDTH + 2;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic [c_PW-1:0]      r_out;
  logic [c_PW-1:0]      r_skid;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_res;
  logic                 w_slt;
  logic                 w_ill;
  logic                 w_zero;
  logic [c_PW-1:0]      w_new;
  logic                 w_accept;
  logic                 w_drain;

  assign w_sum  = opA + opB;
  assign w_diff = opA - opB;

  // Sign-aware compare: differing signs decide directly, so a wrapped difference never matters
  assign w_slt  = (opA[WIDTH-1] ^ opB[WIDTH-1]) ? opA[WIDTH-1] : w_diff[WIDTH-1];

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (ALUOperation)
      c_OP_AND: w_res = opA & opB;
      c_OP_OR:  w_res = opA | opB;
      c_OP_ADD: w_res = w_sum;
      c_OP_SUB: w_res = w_diff;
      c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      default:  w_ill = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);

`ifdef ALU_OVF_FLAG_EN
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (ALUOperation)
      c_OP_ADD: w_ovf = (opA[WIDTH-1] == opB[WIDTH-1]) && (w_sum[WIDTH-1]  != opA[WIDTH-1]);
      c_OP_SUB: w_ovf = (opA[WIDTH-1] != opB[WIDTH-1]) && (w_diff[WIDTH-1] != opA[WIDTH-1]);
      default:  w_ovf = 1'b0;
    endcase
  end

  assign w_new = {w_ovf, w_ill, w_zero, w_res};
`else
  assign w_new = {w_ill, w_zero, w_res};
`endif

  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid & r_in_ready;
  assign w_drain   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_out   <= w_new;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_drain) begin
            r_skid     <= w_new;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_accept && w_drain) begin
            r_out <= w_new;
          end else if (w_drain) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so nothing new can arrive alongside the drain
          if (w_drain) begin
            r_out      <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign result     = r_out[WIDTH-1:0];
  assign zero       = r_out[WIDTH];
  assign illegal_op = r_out[WIDTH+1];
`ifdef ALU_OVF_FLAG_EN
  assign overflow   = r_out[WIDTH+2];
`endif
  assign op_count   = r_cnt;

endmodule

`default_nettype wire
